// File: rtl/core_mc.sv
`default_nettype none
// ============================================================================
// Module   : core_mc
// Brief    : Multi-cycle RV32I/RV32E core (FETCH/EXEC/MEM/HALT) that talks to
//            instruction and data memory over valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module core_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        err
);

    localparam int         c_AW     = (NREGS == 16) ? 4 : 5;
    localparam logic [6:0] c_OP_R   = 7'h33;
    localparam logic [6:0] c_OP_I   = 7'h13;
    localparam logic [6:0] c_OP_LD  = 7'h03;
    localparam logic [6:0] c_OP_ST  = 7'h23;
    localparam logic [6:0] c_OP_BR  = 7'h63;
    localparam logic [6:0] c_OP_JAL = 7'h6F;
    localparam logic [6:0] c_OP_JLR = 7'h67;
    localparam logic [6:0] c_OP_LUI = 7'h37;
    localparam logic [6:0] c_OP_AUI = 7'h17;
    localparam logic [6:0] c_OP_SYS = 7'h73;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic              r_retire;
    logic              r_err;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [31:0]       r_dmem_addr;
    logic [31:0]       r_dmem_wdata;
    logic [c_AW-1:0]   r_rd;
    logic [31:0]       r_rf [NREGS];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_pc4;
    logic [31:0] w_mem_addr;
    logic [31:0] w_wb;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_take;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rd;
    logic        w_illegal;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_sys;
    logic        w_reg_fault;
    logic        w_tgt_mis;
    logic        w_mem_mis;

    function automatic logic [31:0] f_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic alt);
        logic [31:0] res;
        case (f3)
            3'b000:  res = alt ? (a - b) : (a + b);
            3'b001:  res = a << b[4:0];
            3'b010:  res = {31'b0, $signed(a) < $signed(b)};
            3'b011:  res = {31'b0, a < b};
            3'b100:  res = a ^ b;
            3'b101:  res = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  res = a | b;
            default: res = a & b;
        endcase
        return res;
    endfunction

    function automatic logic f_branch(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3);
        logic res;
        case (f3)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = $signed(a) <  $signed(b);
            3'b101:  res = $signed(a) >= $signed(b);
            3'b110:  res = (a <  b);
            3'b111:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_opcode  = r_ir[6:0];
    assign w_rd      = r_ir[11:7];
    assign w_f3      = r_ir[14:12];
    assign w_rs1     = r_ir[19:15];
    assign w_rs2     = r_ir[24:20];
    assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u   = {r_ir[31:12], 12'b0};
    assign w_imm_j   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_rs1_val = r_rf[w_rs1[c_AW-1:0]];
    assign w_rs2_val = r_rf[w_rs2[c_AW-1:0]];
    assign w_pc4     = r_pc + 32'd4;
    assign w_mem_addr = w_rs1_val + ((w_opcode == c_OP_ST) ? w_imm_s : w_imm_i);

    always_comb begin
        w_wb      = 32'd0;
        w_take    = 1'b0;
        w_target  = 32'd0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_illegal = 1'b0;
        w_is_ld   = 1'b0;
        w_is_st   = 1'b0;
        w_sys     = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_wb      = f_alu(w_rs1_val, w_rs2_val, w_f3, r_ir[30]);
            end
            c_OP_I: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                // Only SRAI borrows bit 30; ADDI never subtracts.
                w_wb      = f_alu(w_rs1_val, w_imm_i, w_f3, (w_f3 == 3'b101) && r_ir[30]);
            end
            c_OP_LD: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_is_ld   = (w_f3 == 3'b010);
                w_illegal = (w_f3 != 3'b010);
            end
            c_OP_ST: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_is_st   = (w_f3 == 3'b010);
                w_illegal = (w_f3 != 3'b010);
            end
            c_OP_BR: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_take    = f_branch(w_rs1_val, w_rs2_val, w_f3);
                w_target  = r_pc + w_imm_b;
            end
            c_OP_JAL: begin
                w_use_rd  = 1'b1;
                w_take    = 1'b1;
                w_target  = r_pc + w_imm_j;
                w_wb      = w_pc4;
            end
            c_OP_JLR: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_take    = 1'b1;
                w_target  = (w_rs1_val + w_imm_i) & ~32'd1;
                w_wb      = w_pc4;
            end
            c_OP_LUI: begin
                w_use_rd  = 1'b1;
                w_wb      = w_imm_u;
            end
            c_OP_AUI: begin
                w_use_rd  = 1'b1;
                w_wb      = r_pc + w_imm_u;
            end
            c_OP_SYS: begin
                w_sys     = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_reg_fault = (NREGS == 16) && ((w_use_rs1 && w_rs1[4]) ||
                                           (w_use_rs2 && w_rs2[4]) ||
                                           (w_use_rd  && w_rd[4]));
    assign w_tgt_mis   = w_take && (w_target[1:0] != 2'b00);
    assign w_mem_mis   = (w_is_ld || w_is_st) && (w_mem_addr[1:0] != 2'b00);
    assign w_next_pc   = w_take ? w_target : w_pc4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= 32'd0;
            r_retire     <= 1'b0;
            r_err        <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_rd         <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_illegal || w_reg_fault) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else if (w_sys) begin
                        r_err   <= 1'b0;
                        r_state <= S_HALT;
                    end else if (w_tgt_mis || w_mem_mis) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else if (w_is_ld || w_is_st) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_st;
                        r_dmem_addr  <= w_mem_addr;
                        r_dmem_wdata <= w_rs2_val;
                        r_rd         <= w_rd[c_AW-1:0];
                        r_state      <= S_MEM;
                    end else begin
                        if (w_use_rd && (w_rd != 5'd0)) begin
                            r_rf[w_rd[c_AW-1:0]] <= w_wb;
                        end
                        r_pc     <= w_next_pc;
                        r_retire <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (!r_dmem_we && (r_rd != '0)) begin
                            r_rf[r_rd] <= dmem_rdata;
                        end
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc       <= w_pc4;
                        r_retire   <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Fetch request follows the state directly so the first fetch issues in
    // the cycle right after reset; it is masked while rst is still held.
    assign imem_req   = (r_state == S_FETCH) && !rst;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc         = r_pc;
    assign retire     = r_retire;
    assign halted     = (r_state == S_HALT);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_mc
// Brief    : Directed self-checking bench for core_mc (RV32I and RV32E builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RV32I instance
    logic        rst_a;
    logic        imem_req_a;
    logic [31:0] imem_addr_a;
    logic        imem_ready_a;
    logic [31:0] imem_rdata_a;
    logic        dmem_req_a;
    logic        dmem_we_a;
    logic [31:0] dmem_addr_a;
    logic [31:0] dmem_wdata_a;
    logic        dmem_ready_a;
    logic [31:0] dmem_rdata_a;
    logic [31:0] pc_a;
    logic        retire_a;
    logic        halted_a;
    logic        err_a;

    // RV32E instance
    logic        rst_b;
    logic        imem_req_b;
    logic [31:0] imem_addr_b;
    logic [31:0] imem_rdata_b;
    logic        dmem_req_b;
    logic        dmem_we_b;
    logic [31:0] dmem_addr_b;
    logic [31:0] dmem_wdata_b;
    logic [31:0] pc_b;
    logic        retire_b;
    logic        halted_b;
    logic        err_b;

    logic [31:0] imem_a [0:255];
    logic [31:0] imem_b [0:255];
    logic [31:0] dmem   [0:255];

    assign imem_rdata_a = imem_a[imem_addr_a[9:2]];
    assign imem_rdata_b = imem_b[imem_addr_b[9:2]];

    core_mc #(.RESET_PC(32'h0), .NREGS(32)) u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .imem_req   (imem_req_a),
        .imem_addr  (imem_addr_a),
        .imem_ready (imem_ready_a),
        .imem_rdata (imem_rdata_a),
        .dmem_req   (dmem_req_a),
        .dmem_we    (dmem_we_a),
        .dmem_addr  (dmem_addr_a),
        .dmem_wdata (dmem_wdata_a),
        .dmem_ready (dmem_ready_a),
        .dmem_rdata (dmem_rdata_a),
        .pc         (pc_a),
        .retire     (retire_a),
        .halted     (halted_a),
        .err        (err_a)
    );

    core_mc #(.RESET_PC(32'h0), .NREGS(16)) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .imem_req   (imem_req_b),
        .imem_addr  (imem_addr_b),
        .imem_ready (1'b1),
        .imem_rdata (imem_rdata_b),
        .dmem_req   (dmem_req_b),
        .dmem_we    (dmem_we_b),
        .dmem_addr  (dmem_addr_b),
        .dmem_wdata (dmem_wdata_b),
        .dmem_ready (1'b1),
        .dmem_rdata (32'h0),
        .pc         (pc_b),
        .retire     (retire_b),
        .halted     (halted_b),
        .err        (err_b)
    );

    int errors = 0;
    int checks = 0;

    // Data slave with programmable wait states; logs stores it accepts.
    int          dwait  = 2;
    int          dcnt   = 0;
    int          st_cnt = 0;
    logic [31:0] st_addr [0:7];
    logic [31:0] st_data [0:7];

    initial begin
        dmem_ready_a = 1'b0;
        dmem_rdata_a = 32'h0;
    end

    always @(negedge clk) begin
        if (dmem_ready_a) begin
            dmem_ready_a = 1'b0;
            dcnt = 0;
        end else if (dmem_req_a) begin
            if (dcnt >= dwait) begin
                dmem_ready_a = 1'b1;
                if (dmem_we_a) begin
                    dmem[dmem_addr_a[9:2]] = dmem_wdata_a;
                    if (st_cnt < 8) begin
                        st_addr[st_cnt] = dmem_addr_a;
                        st_data[st_cnt] = dmem_wdata_a;
                    end
                    st_cnt++;
                end else begin
                    dmem_rdata_a = dmem[dmem_addr_a[9:2]];
                end
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
    end

    int ret_cnt  = 0;
    int ovl_cnt  = 0;
    int hreq_cnt = 0;
    always @(negedge clk) begin
        if (retire_a) ret_cnt++;
        if (imem_req_a && dmem_req_a) ovl_cnt++;
        if (halted_a && (imem_req_a || dmem_req_a)) hreq_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int ret_snap;
        for (int i = 0; i < 256; i++) begin
            imem_a[i] = 32'h0;
            imem_b[i] = 32'h0;
            dmem[i]   = 32'h0;
        end
        imem_a[0]  = 32'h00500093; // ADDI x1, x0, 5
        imem_a[1]  = 32'h00102423; // SW   x1, 8(x0)
        imem_a[2]  = 32'h00802103; // LW   x2, 8(x0)
        imem_a[3]  = 32'h00202623; // SW   x2, 12(x0)
        imem_a[4]  = 32'h10100193; // ADDI x3, x0, 0x101
        imem_a[5]  = 32'h00018267; // JALR x4, 0(x3) -> 0x100
        imem_a[64] = 32'h00402823; // SW   x4, 16(x0)
        imem_a[65] = 32'h00000363; // BEQ  x0, x0, +6 (misaligned)
        imem_b[0]  = 32'h00100093; // ADDI x1, x0, 1
        imem_b[1]  = 32'h00000073; // ECALL

        rst_a = 1'b1;
        rst_b = 1'b1;
        imem_ready_a = 1'b1;

        // Reset then ADDI with zero-wait fetch
        tick();
        tick();
        rst_a = 1'b0;
        ret_cnt = 0;
        #1;
        chk("rst_imem_req",  32'(imem_req_a), 32'd1);
        chk("rst_imem_addr", imem_addr_a, 32'h0);
        chk("rst_dmem_req",  32'(dmem_req_a), 32'd0);
        chk("rst_retire",    32'(retire_a), 32'd0);
        chk("rst_halted",    32'(halted_a), 32'd0);
        chk("rst_err",       32'(err_a), 32'd0);
        tick();
        chk("exec_no_req",   32'(imem_req_a), 32'd0);
        chk("exec_retire",   32'(retire_a), 32'd0);
        tick();
        chk("addi_retire",   32'(retire_a), 32'd1);
        chk("addi_pc",       pc_a, 32'h4);

        // Run the program up to the misaligned branch
        n = 0;
        while (!halted_a && n < 300) begin
            tick();
            n++;
        end
        chk("br_halted",     32'(halted_a), 32'd1);
        chk("br_err",        32'(err_a), 32'd1);
        chk("br_pc",         pc_a, 32'h104);
        chk("store_count",   32'(st_cnt), 32'd3);
        chk("sw1_addr",      st_addr[0], 32'h8);
        chk("sw1_data",      st_data[0], 32'h5);
        chk("lw_via_sw2_addr", st_addr[1], 32'hC);
        chk("lw_via_sw2_data", st_data[1], 32'h5);
        chk("jalr_link_addr",  st_addr[2], 32'h10);
        chk("jalr_link_data",  st_data[2], 32'h18);
        chk("retire_count",  32'(ret_cnt), 32'd7);
        chk("no_overlap",    32'(ovl_cnt), 32'd0);
        repeat (5) tick();
        chk("halt_no_req",   32'(hreq_cnt), 32'd0);
        chk("halt_pc_frozen", pc_a, 32'h104);

        // Reset out of HALT, then fetch stalled for 3 cycles
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        imem_ready_a = 1'b0;
        ret_cnt = 0;
        #1;
        chk("rst_from_halt", 32'(halted_a), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("stall_req",  32'(imem_req_a), 32'd1);
            chk("stall_addr", imem_addr_a, 32'h0);
            if (k < 3) tick();
        end
        imem_ready_a = 1'b1;
        tick();
        imem_ready_a = 1'b0;
        repeat (4) tick();
        chk("stall_one_retire", 32'(ret_cnt), 32'd1);
        chk("stall_pc",         pc_a, 32'h4);

        // Reset during a long LW wait
        rst_a = 1'b1;
        imem_ready_a = 1'b1;
        dwait = 10;
        tick();
        rst_a = 1'b0;
        n = 0;
        while (!(dmem_req_a && !dmem_we_a) && n < 200) begin
            tick();
            n++;
        end
        chk("lw_req_seen", 32'(dmem_req_a), 32'd1);
        chk("lw_addr",     dmem_addr_a, 32'h8);
        ret_snap = ret_cnt;
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        chk("mrst_dmem_req", 32'(dmem_req_a), 32'd0);
        chk("mrst_pc",       pc_a, 32'h0);
        chk("mrst_retire",   32'(retire_a), 32'd0);
        chk("mrst_no_retire", 32'(ret_cnt), 32'(ret_snap));
        rst_a = 1'b0;
        #1;
        chk("mrst_refetch",  32'(imem_req_a), 32'd1);

        // RV32E: ECALL halts cleanly, then x17 faults
        rst_b = 1'b0;
        n = 0;
        while (!halted_b && n < 50) begin
            tick();
            n++;
        end
        chk("ecall_halted", 32'(halted_b), 32'd1);
        chk("ecall_err",    32'(err_b), 32'd0);
        chk("ecall_pc",     pc_b, 32'h4);
        rst_b = 1'b1;
        imem_b[1] = 32'h00100893; // ADDI x17, x0, 1
        tick();
        chk("e_rst_halted", 32'(halted_b), 32'd0);
        rst_b = 1'b0;
        n = 0;
        while (!halted_b && n < 50) begin
            tick();
            n++;
        end
        chk("x17_halted", 32'(halted_b), 32'd1);
        chk("x17_err",    32'(err_b), 32'd1);
        chk("x17_pc",     pc_b, 32'h4);
        chk("x17_no_req", 32'(imem_req_b || dmem_req_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
